// File: rtl/icache_scm_bist_ctrl.sv
// March-test BIST engine for the 2R2W icache SCM: pattern, inverse pattern, address-as-data.
// Optional macro ICACHE_SCM_BIST_EARLY_ABORT_EN: the first mismatch ends the run in DONE.
module icache_scm_bist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic                  ren_a_o,
  output logic [ADDR_WIDTH-1:0] raddr_a_o,
  input  logic [DATA_WIDTH-1:0] rdata_a_i,
  output logic                  ren_b_o,
  output logic [ADDR_WIDTH-1:0] raddr_b_o,
  input  logic [DATA_WIDTH-1:0] rdata_b_i,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int HALF  = DEPTH / 2;
  localparam int KW    = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

  function automatic logic [DATA_WIDTH-1:0] gen_pat();
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) p[i] = ((i % 2) == 1);
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] PAT = gen_pat();

  // Phase states are consecutive so a finished phase advances by +1.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_W_PAT = 4'd1,
    S_R_PAT = 4'd2,
    S_W_INV = 4'd3,
    S_R_INV = 4'd4,
    S_W_ADR = 4'd5,
    S_R_ADR = 4'd6,
    S_DRAIN = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] phase_data(input state_e s,
                                                       input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    case (s)
      S_W_PAT, S_R_PAT: d = PAT;
      S_W_INV, S_R_INV: d = ~PAT;
      S_W_ADR, S_R_ADR: d = DATA_WIDTH'(a);
      default:          d = '0;
    endcase
    return d;
  endfunction

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  busy_q, done_q, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic                  ren_a_q, ren_b_q, we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] raddr_a_q, raddr_b_q, waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;
  logic                  cmp_valid_q;
  logic [DATA_WIDTH-1:0] exp_a_q, exp_b_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;

  logic                  start_ok;
  logic                  mis_a, mis_b, mismatch;
  logic [ADDR_WIDTH-1:0] mis_addr;
  logic                  is_wr_d, is_rd_d;
  logic [ADDR_WIDTH-1:0] addr_a_d, addr_b_d;

  assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

  // Read data returns one cycle after ren; compare against the expectation captured then.
  assign mis_a    = cmp_valid_q && busy_q && (rdata_a_i != exp_a_q);
  assign mis_b    = cmp_valid_q && busy_q && (rdata_b_i != exp_b_q);
  assign mismatch = mis_a || mis_b;
  assign mis_addr = mis_a ? cmp_addr_q : (cmp_addr_q | ADDR_WIDTH'(1));

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_W_PAT;
          k_d     = '0;
        end
      end
      S_W_PAT, S_R_PAT, S_W_INV, S_R_INV, S_W_ADR, S_R_ADR: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = state_e'(state_q + 4'd1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
`ifdef ICACHE_SCM_BIST_EARLY_ABORT_EN
    if (mismatch) begin
      state_d = S_DONE;
      k_d     = '0;
    end
`endif
  end

  assign is_wr_d  = (state_d == S_W_PAT) || (state_d == S_W_INV) || (state_d == S_W_ADR);
  assign is_rd_d  = (state_d == S_R_PAT) || (state_d == S_R_INV) || (state_d == S_R_ADR);
  assign addr_a_d = ADDR_WIDTH'({k_d, 1'b0});
  assign addr_b_d = ADDR_WIDTH'({k_d, 1'b1});

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      ren_a_q     <= 1'b0;
      ren_b_q     <= 1'b0;
      raddr_a_q   <= '0;
      raddr_b_q   <= '0;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      waddr_a_q   <= '0;
      waddr_b_q   <= '0;
      wdata_a_q   <= '0;
      wdata_b_q   <= '0;
      cmp_valid_q <= 1'b0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      cmp_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);

      // Strobes are registered from the next state; address/data forced to 0 when idle.
      we_a_q    <= is_wr_d;
      we_b_q    <= is_wr_d;
      waddr_a_q <= is_wr_d ? addr_a_d : '0;
      waddr_b_q <= is_wr_d ? addr_b_d : '0;
      wdata_a_q <= is_wr_d ? phase_data(state_d, addr_a_d) : '0;
      wdata_b_q <= is_wr_d ? phase_data(state_d, addr_b_d) : '0;
      ren_a_q   <= is_rd_d;
      ren_b_q   <= is_rd_d;
      raddr_a_q <= is_rd_d ? addr_a_d : '0;
      raddr_b_q <= is_rd_d ? addr_b_d : '0;

      cmp_valid_q <= ren_a_q;
      exp_a_q     <= ren_a_q ? phase_data(state_q, raddr_a_q) : '0;
      exp_b_q     <= ren_b_q ? phase_data(state_q, raddr_b_q) : '0;
      cmp_addr_q  <= raddr_a_q;

      if (start_ok) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
        if (!fail_q) fail_addr_q <= mis_addr;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign ren_a_o     = ren_a_q;
  assign raddr_a_o   = raddr_a_q;
  assign ren_b_o     = ren_b_q;
  assign raddr_b_o   = raddr_b_q;
  assign we_a_o      = we_a_q;
  assign waddr_a_o   = waddr_a_q;
  assign wdata_a_o   = wdata_a_q;
  assign we_b_o      = we_b_q;
  assign waddr_b_o   = waddr_b_q;
  assign wdata_b_o   = wdata_b_q;

endmodule
